add_accum_pipe: RTL and testbench

//   Parametrised successor to the registered two-operand adder datapath: a 2-stage

---
 rtl/add_accum_pipe.sv | 136 +++++++++++++
 tb/tb_add_accum_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_accum_pipe.sv
// add_accum_pipe: two-stage pipelined adder/accumulator with valid/ready on both sides.
// Stage 1 registers the accepted operands. Stage 2 forms the sum or the accumulation
// and registers the result, the overflow flag and the accumulator.
// Both stages advance together whenever the output register is free or being drained.
module add_accum_pipe #(
    parameter int WIDTH  = 32,
    parameter int GUARD  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_mode,
    input  logic                   in_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+GUARD-1:0] out_result,
    output logic                   out_ovf
);

    localparam int OUT_W = WIDTH + GUARD;
    // Two extra bits hold the exact value of a three-term sum, so overflow can be read off the top bits.
    localparam int EXT_W = OUT_W + 2;

    logic             en;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_mode_q, s1_mode_d;
    logic             s1_clear_q, s1_clear_d;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_result_q, out_result_d;
    logic             out_ovf_q, out_ovf_d;
    logic [OUT_W-1:0] acc_q, acc_d;

    logic [OUT_W-1:0] ea, eb, base, plain_sum;
    logic [EXT_W-1:0] xa, xb, xbase, xsum;
    logic             acc_ovf;

    // A stalled output register freezes the whole pipe; otherwise both stages move.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_result = out_result_q;
    assign out_ovf   = out_ovf_q;

    // Extend the stage-1 operands and the accumulator base, then form the plain and accumulated sums.
    always_comb begin
        ea = {{GUARD{1'b0}}, s1_a_q};
        eb = {{GUARD{1'b0}}, s1_b_q};
        if (SIGNED) begin
            ea = {{GUARD{s1_a_q[WIDTH-1]}}, s1_a_q};
            eb = {{GUARD{s1_b_q[WIDTH-1]}}, s1_b_q};
        end
        base      = s1_clear_q ? '0 : acc_q;
        // GUARD >= 1 keeps this two-term sum exact, so mode 0 never overflows.
        plain_sum = ea + eb;

        xa    = {{2{SIGNED & ea[OUT_W-1]}}, ea};
        xb    = {{2{SIGNED & eb[OUT_W-1]}}, eb};
        xbase = {{2{SIGNED & base[OUT_W-1]}}, base};
        xsum  = xbase + xa + xb;

        // Unsigned: any weight at or above 2^OUT_W. Signed: the top three bits disagree.
        if (SIGNED) begin
            acc_ovf = (xsum[EXT_W-1:OUT_W-1] != 3'b000) && (xsum[EXT_W-1:OUT_W-1] != 3'b111);
        end else begin
            acc_ovf = |xsum[EXT_W-1:OUT_W];
        end
    end

    // Next-state for both stages and the accumulator; everything holds while en is low.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_mode_d    = s1_mode_q;
        s1_clear_d   = s1_clear_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        acc_d        = acc_q;

        if (en) begin
            s1_valid_d  = in_valid;
            s1_a_d      = in_a;
            s1_b_d      = in_b;
            s1_mode_d   = in_mode;
            s1_clear_d  = in_clear;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_mode_q) begin
                    // acc is written in the same edge as the result, so a following
                    // mode-1 transaction already in stage 1 sees it without a bubble.
                    out_result_d = xsum[OUT_W-1:0];
                    out_ovf_d    = acc_ovf;
                    acc_d        = xsum[OUT_W-1:0];
                end else begin
                    out_result_d = plain_sum;
                    out_ovf_d    = 1'b0;
                end
            end
        end
    end

    // Control and result state, cleared by synchronous reset; in-flight work is dropped.
    always_ff @(posedge clk) begin
        if (RST) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            acc_q        <= acc_d;
        end
    end

    // Stage-1 payload needs no reset: it is only consumed when s1_valid_q is set.
    always_ff @(posedge clk) begin
        s1_a_q     <= s1_a_d;
        s1_b_q     <= s1_b_d;
        s1_mode_q  <= s1_mode_d;
        s1_clear_q <= s1_clear_d;
    end

endmodule

// File: tb/tb_add_accum_pipe.sv
// Bench for add_accum_pipe: an unsigned and a signed instance share one stimulus stream.
// A reference model fills per-instance expectation queues at accept time; a forked
// monitor pops them as results are handed off. Directed checks cover the spec vectors.
module tb_add_accum_pipe;

    localparam int WIDTH = 32;
    localparam int GUARD = 8;
    localparam int OUT_W = WIDTH + GUARD;

    typedef struct packed {
        logic [OUT_W-1:0] res;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_mode, in_clear, out_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             in_ready_u, in_ready_s;
    logic             out_valid_u, out_valid_s;
    logic             out_ovf_u, out_ovf_s;
    logic [OUT_W-1:0] out_result_u, out_result_s;

    int               checks = 0;
    int               errors = 0;
    exp_t             q_u[$];
    exp_t             q_s[$];
    logic [OUT_W-1:0] acc_u, acc_s;

    always #5 clk = ~clk;

    add_accum_pipe #(.WIDTH(WIDTH), .GUARD(GUARD), .SIGNED(1'b0)) dut_u (
        .clk(clk), .RST(rst),
        .in_valid(in_valid), .in_ready(in_ready_u),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_clear(in_clear),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .out_result(out_result_u), .out_ovf(out_ovf_u)
    );

    add_accum_pipe #(.WIDTH(WIDTH), .GUARD(GUARD), .SIGNED(1'b1)) dut_s (
        .clk(clk), .RST(rst),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_clear(in_clear),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_result(out_result_s), .out_ovf(out_ovf_s)
    );

    // Exact arithmetic in 64 bits, then a range test for overflow.
    function automatic exp_t model(input bit sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input bit mode, input bit clear, input logic [OUT_W-1:0] acc);
        longint ea, eb, base, sum;
        exp_t   e;
        if (sgn) begin
            ea   = longint'($signed(a));
            eb   = longint'($signed(b));
            base = longint'($signed(acc));
        end else begin
            ea   = longint'({32'b0, a});
            eb   = longint'({32'b0, b});
            base = longint'({24'b0, acc});
        end
        if (!mode) begin
            sum   = ea + eb;
            e.ovf = 1'b0;
        end else begin
            if (clear) base = 0;
            sum = base + ea + eb;
            if (sgn) e.ovf = (sum > ((64'sd1 <<< 39) - 1)) || (sum < -(64'sd1 <<< 39));
            else     e.ovf = (sum >= (64'sd1 <<< 40));
        end
        e.res = sum[OUT_W-1:0];
        return e;
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit mode, input bit clear);
        exp_t e;
        e = model(1'b0, a, b, mode, clear, acc_u);
        q_u.push_back(e);
        if (mode) acc_u = e.res;
        e = model(1'b1, a, b, mode, clear, acc_s);
        q_s.push_back(e);
        if (mode) acc_s = e.res;
    endtask

    task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one transaction; it is accepted at the first edge where in_ready is high.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit mode, input bit clear);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; in_clear = clear;
        @(negedge clk);
        while (!in_ready_u && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL send_timeout: in_ready low for %0d cycles, expected accept within 200", n);
        end
        if (n < 200) push_exp(a, b, mode, clear);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_u.size() != 0 || q_s.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q_u.size(), q_s.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_ready && out_valid_u) begin
                checks++;
                assert (q_u.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_u_extra: observed result %h, expected no output", out_result_u);
                end
                if (q_u.size() != 0) begin
                    e = q_u.pop_front();
                    checks++;
                    assert ({out_result_u, out_ovf_u} === {e.res, e.ovf}) else begin
                        errors++;
                        $error("FAIL sb_u: observed %h ovf %b expected %h ovf %b", out_result_u, out_ovf_u, e.res, e.ovf);
                    end
                end
            end
            if (!rst && out_ready && out_valid_s) begin
                checks++;
                assert (q_s.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_s_extra: observed result %h, expected no output", out_result_s);
                end
                if (q_s.size() != 0) begin
                    e = q_s.pop_front();
                    checks++;
                    assert ({out_result_s, out_ovf_s} === {e.res, e.ovf}) else begin
                        errors++;
                        $error("FAIL sb_s: observed %h ovf %b expected %h ovf %b", out_result_s, out_ovf_s, e.res, e.ovf);
                    end
                end
            end
        end
    endtask

    initial begin
        int k;
        int n_acc;
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_clear = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        acc_u = '0; acc_s = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid_u", {39'b0, out_valid_u}, 40'd0);
        chk("rst_out_valid_s", {39'b0, out_valid_s}, 40'd0);
        chk("rst_out_result_u", out_result_u, 40'd0);
        chk("rst_out_ovf_u", {39'b0, out_ovf_u}, 40'd0);
        chk("rst_in_ready_u", {39'b0, in_ready_u}, 40'd1);
        chk("rst_in_ready_s", {39'b0, in_ready_s}, 40'd1);
        @(posedge clk); #1;

        // vector 1: unsigned carry into guard, latency 2
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_valid", {39'b0, out_valid_u}, 40'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {39'b0, out_valid_u}, 40'd1);
        chk("v1_result_u", out_result_u, 40'h01_0000_0000);
        chk("v1_ovf_u", {39'b0, out_ovf_u}, 40'd0);
        chk("v1_result_s", out_result_s, 40'h00_0000_0000);
        @(posedge clk); #1;
        drain();

        // vector 2: unsigned accumulate until the 129th wraps
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        for (int i = 0; i < 128; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drain();
        chk("v2_last_u", out_result_u, 40'h01_FFFF_FEFE);
        chk("v2_last_ovf_u", {39'b0, out_ovf_u}, 40'd1);
        chk("v2_last_s", out_result_s, 40'hFF_FFFF_FEFE);
        chk("v2_last_ovf_s", {39'b0, out_ovf_s}, 40'd0);

        // vector 3: signed extension, then signed accumulate until positive overflow
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain();
        chk("v3_neg_s", out_result_s, 40'hFF_0000_0000);
        chk("v3_neg_ovf_s", {39'b0, out_ovf_s}, 40'd0);
        chk("v3_neg_u", out_result_u, 40'h01_0000_0000);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1);
        drain();
        chk("v3_pos_s", out_result_s, 40'h00_FFFF_FFFE);
        for (int i = 0; i < 128; i++) send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
        drain();
        chk("v3_wrap_s", out_result_s, 40'h80_FFFF_FEFE);
        chk("v3_wrap_ovf_s", {39'b0, out_ovf_s}, 40'd1);
        chk("v3_wrap_ovf_u", {39'b0, out_ovf_u}, 40'd0);

        // vector 4: stall with a continuous offer; only two fit
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_clear = 1'b0; in_b = '0;
        k = 5; in_a = 32'(k); n_acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ready_u) begin
                push_exp(32'(k), 32'd0, 1'b0, 1'b0);
                n_acc++;
                @(posedge clk); #1;
                k++;
                in_a = 32'(k);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("v4_accepted", 40'(n_acc), 40'd2);
        @(negedge clk);
        chk("v4_in_ready", {39'b0, in_ready_u}, 40'd0);
        chk("v4_held_result", out_result_u, 40'd5);
        chk("v4_held_valid", {39'b0, out_valid_u}, 40'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("v4_rel_first", out_result_u, 40'd5);
        @(negedge clk);
        chk("v4_rel_second", out_result_u, 40'd6);
        chk("v4_rel_second_valid", {39'b0, out_valid_u}, 40'd1);
        @(posedge clk); #1;
        drain();

        // vector 5: clear, intervening mode 0, then continue accumulating
        send(32'd100, 32'd0, 1'b1, 1'b1);
        send(32'd5, 32'd6, 1'b1, 1'b1);
        send(32'd1, 32'd1, 1'b0, 1'b1);
        send(32'd1, 32'd0, 1'b1, 1'b0);
        drain();
        chk("v5_final_u", out_result_u, 40'd12);
        chk("v5_final_s", out_result_s, 40'd12);

        // vector 6: reset with two in flight drops both and clears acc
        send(32'd9, 32'd9, 1'b0, 1'b0);
        send(32'd8, 32'd8, 1'b1, 1'b0);
        rst = 1'b1;
        q_u.delete(); q_s.delete();
        acc_u = '0; acc_s = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("v6_valid_u", {39'b0, out_valid_u}, 40'd0);
        chk("v6_result_u", out_result_u, 40'd0);
        @(negedge clk);
        chk("v6_no_late_valid", {39'b0, out_valid_u}, 40'd0);
        @(posedge clk); #1;
        send(32'd3, 32'd4, 1'b1, 1'b0);
        drain();
        chk("v6_after_u", out_result_u, 40'd7);
        chk("v6_after_s", out_result_s, 40'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
